// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and transmitter-side signals of the UART TX scheduler.
// The scheduler is the slave; the requesters and transmitter side are the master.
interface uart_tx_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [7:0]           tx_data;
    logic                 tx_send;
    logic                 tx_finish;
    logic                 busy;
    logic [ID_W-1:0]      active_id;
    logic                 timeout_err;

    modport slave (
        input  req, req_data, tx_finish,
        output ack, tx_data, tx_send, busy, active_id, timeout_err
    );

    modport master (
        output req, req_data, tx_finish,
        input  ack, tx_data, tx_send, busy, active_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters,
// with a watchdog that abandons a transfer whose completion edge never arrives.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int unsigned     ID_W    = $clog2(NUM_REQ);
    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               tx_finish_q;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_send_q, tx_send_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;

    logic               finish_edge;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    next_id;

    // Only a fresh 0->1 transition counts; a level left high by a previous frame is ignored.
    assign finish_edge = bus.tx_finish & ~tx_finish_q;
    assign next_id     = (active_id_q == ID_LAST) ? '0 : active_id_q + ID_W'(1);

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_vld && bus.req[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        wd_d          = wd_q;
        tx_data_d     = tx_data_q;
        active_id_d   = active_id_q;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d     = SEND;
                    active_id_d = grant_id;
                    tx_data_d   = bus.req_data[{grant_id, 3'b000} +: 8];
                end
            end
            SEND: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion edge has priority over an expiring watchdog.
                if (finish_edge) begin
                    state_d = DONE;
                end else if (wd_q == WD_LAST) begin
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = next_id;
                    state_d       = IDLE;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DONE: begin
                rr_ptr_d = next_id;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        tx_send_d = (state_d == SEND);
        busy_d    = (state_d != IDLE);
        ack_d     = '0;
        if (state_d == DONE) begin
            ack_d[active_id_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            wd_q          <= '0;
            tx_finish_q   <= 1'b0;
            tx_data_q     <= '0;
            active_id_q   <= '0;
            ack_q         <= '0;
            tx_send_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            wd_q          <= wd_d;
            tx_finish_q   <= bus.tx_finish;
            tx_data_q     <= tx_data_d;
            active_id_q   <= active_id_d;
            ack_q         <= ack_d;
            tx_send_q     <= tx_send_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_send     = tx_send_q;
    assign bus.busy        = busy_q;
    assign bus.active_id   = active_id_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a transaction-level model per instance checked every cycle,
// plus directed scenarios with literal expectations on grant order, bytes and latencies.
module tb_uart_tx_scheduler;
    localparam int N   = 4;
    localparam int T_A = 1_200_000;
    localparam int T_B = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(N)) ia ();
    uart_tx_scheduler_if #(.NUM_REQ(N)) ib ();

    uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T_A)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T_B)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    // Model: a transfer is granted, spends one send cycle, then counts waiting cycles
    // until a fresh completion edge (ack next cycle) or t waiting cycles elapse (abort).
    typedef struct {
        int         ptr;
        bit         serving;
        bit         acking;
        int         wait_n;
        bit         fin_prev;
        int         id;
        logic [7:0] data;
        bit         send;
        bit         busy;
        bit         terr;
        logic [3:0] ack;
    } model_t;

    model_t ma, mb;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic model_t step(model_t m, logic r, logic [3:0] rq, logic [31:0] rd,
                                    logic fin, int t);
        model_t n = m;
        n.send     = 1'b0;
        n.terr     = 1'b0;
        n.ack      = '0;
        n.fin_prev = fin;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        if (!m.serving) begin
            for (int k = 0; k < N; k++) begin
                int i = (m.ptr + k) % N;
                if (!n.serving && rq[i]) begin
                    n.serving = 1'b1;
                    n.id      = i;
                    n.data    = rd[8*i +: 8];
                    n.send    = 1'b1;
                    n.wait_n  = -1;
                end
            end
        end else if (m.acking) begin
            n.serving = 1'b0;
            n.acking  = 1'b0;
            n.ptr     = (m.id + 1) % N;
        end else if (m.wait_n < 0) begin
            n.wait_n = 0;
        end else if (fin && !m.fin_prev) begin
            n.acking    = 1'b1;
            n.ack[m.id] = 1'b1;
        end else if (m.wait_n == t - 1) begin
            n.serving = 1'b0;
            n.terr    = 1'b1;
            n.ptr     = (m.id + 1) % N;
        end else begin
            n.wait_n = m.wait_n + 1;
        end
        n.busy = n.serving;
        return n;
    endfunction

    function automatic logic [16:0] pack_exp(model_t m);
        return {m.ack, m.data, m.send, m.busy, 2'(m.id), m.terr};
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, rst, ia.req, ia.req_data, ia.tx_finish, T_A);
        mb <= step(mb, rst, ib.req, ib.req_data, ib.tx_finish, T_B);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_send(input bit use_b, input string nm, output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if ((use_b ? ib.tx_send : ia.tx_send) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(nm, 64'(seen), 64'd1);
    endtask

    // One full transfer on instance A: grant, byte, completion edge after dly cycles, ack.
    task automatic xfer_a(input logic [3:0] r, input int dly, input int exp_id,
                          input logic [7:0] exp_byte);
        bit seen;
        ia.req = r;
        wait_send(1'b0, $sformatf("grant issued id%0d", exp_id), seen);
        if (seen) begin
            check($sformatf("grant id%0d active_id", exp_id), 64'(ia.active_id), 64'(exp_id));
            check($sformatf("grant id%0d tx_data", exp_id), 64'(ia.tx_data), 64'(exp_byte));
            ia.tx_finish = 1'b0;
            repeat (dly) @(negedge clk);
            ia.tx_finish = 1'b1;
            @(negedge clk);
            check($sformatf("ack id%0d", exp_id), 64'(ia.ack), 64'(4'b0001 << exp_id));
        end
    endtask

    initial begin
        bit seen;
        bit any_ack;
        bit got;
        int cnt;

        rst          = 1'b1;
        ia.req       = '0;
        ia.req_data  = 32'h131211A5;
        ia.tx_finish = 1'b0;
        ib.req       = '0;
        ib.req_data  = 32'h44332211;
        ib.tx_finish = 1'b0;
        @(negedge clk);

        fork
            forever begin
                check("dut_a outputs vs model",
                      64'({ia.ack, ia.tx_data, ia.tx_send, ia.busy, ia.active_id, ia.timeout_err}),
                      64'(pack_exp(ma)));
                check("dut_b outputs vs model",
                      64'({ib.ack, ib.tx_data, ib.tx_send, ib.busy, ib.active_id, ib.timeout_err}),
                      64'(pack_exp(mb)));
                @(negedge clk);
            end
        join_none

        check("reset ack", 64'(ia.ack), 64'd0);
        check("reset tx_send", 64'(ia.tx_send), 64'd0);
        check("reset busy", 64'(ia.busy), 64'd0);
        check("reset tx_data", 64'(ia.tx_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single requester, completion 20 cycles after the send pulse.
        xfer_a(4'b0001, 20, 0, 8'hA5);
        ia.req = '0;
        @(negedge clk);
        check("single busy after done", 64'(ia.busy), 64'd0);
        check("single ack cleared", 64'(ia.ack), 64'd0);

        // Stale finish level: tx_finish stays high from the last frame; requester drops req.
        ia.req = 4'b0010;
        wait_send(1'b0, "stale grant issued", seen);
        check("stale grant id", 64'(ia.active_id), 64'd1);
        ia.req  = '0;
        any_ack = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (ia.ack != '0) any_ack = 1'b1;
        end
        check("stale no ack", 64'(any_ack), 64'd0);
        check("stale still busy", 64'(ia.busy), 64'd1);
        ia.tx_finish = 1'b0;
        @(negedge clk);
        ia.tx_finish = 1'b1;
        @(negedge clk);
        check("stale fresh edge ack", 64'(ia.ack), 64'b0010);
        @(negedge clk);

        // Reset in WAIT: pointer was 2, a fresh request set must restart from id 0.
        ia.req = 4'b0100;
        wait_send(1'b0, "pre-reset grant issued", seen);
        check("pre-reset grant id", 64'(ia.active_id), 64'd2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset mid-wait outputs",
              64'({ia.ack, ia.tx_data, ia.tx_send, ia.busy, ia.active_id, ia.timeout_err}), 64'd0);
        rst = 1'b0;
        xfer_a(4'b0101, 3, 0, 8'hA5);
        ia.req = '0;
        @(negedge clk);

        // Round-robin from a clean pointer, then wrap-around.
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        ia.req_data = 32'h13121110;
        @(negedge clk);
        xfer_a(4'b1111, 3, 0, 8'h10);
        xfer_a(4'b1111, 3, 1, 8'h11);
        xfer_a(4'b1111, 4, 2, 8'h12);
        xfer_a(4'b1111, 2, 3, 8'h13);
        xfer_a(4'b1111, 1, 0, 8'h10);
        xfer_a(4'b1000, 3, 3, 8'h13);
        xfer_a(4'b1001, 3, 0, 8'h10);
        xfer_a(4'b1001, 3, 3, 8'h13);
        ia.req = '0;
        repeat (3) @(negedge clk);

        // Watchdog on the 16-cycle instance.
        ib.req = 4'b0110;
        wait_send(1'b1, "timeout grant issued", seen);
        check("timeout grant id", 64'(ib.active_id), 64'd1);
        cnt     = 0;
        got     = 1'b0;
        any_ack = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (ib.ack != '0) any_ack = 1'b1;
            if (ib.timeout_err === 1'b1) begin
                cnt = t;
                got = 1'b1;
                break;
            end
        end
        check("timeout pulse seen", 64'(got), 64'd1);
        check("timeout cycles after send", 64'(cnt), 64'd17);
        check("timeout no ack", 64'(any_ack), 64'd0);
        check("timeout busy low", 64'(ib.busy), 64'd0);

        wait_send(1'b1, "post-timeout grant issued", seen);
        check("post-timeout grant id", 64'(ib.active_id), 64'd2);
        check("post-timeout tx_data", 64'(ib.tx_data), 64'h33);
        repeat (16) @(negedge clk);
        ib.tx_finish = 1'b1;
        @(negedge clk);
        check("edge on last cycle ack", 64'(ib.ack), 64'b0100);
        check("edge on last cycle no timeout", 64'(ib.timeout_err), 64'd0);
        ib.req = '0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte-producing requesters. It sits between the requesters and the `uart_tx` instance. It latches one requester's byte, pulses `tx_send`, and waits for the transmitter's completion flag. It then acknowledges the requester and moves priority to the next one. A watchdog counter recovers the schedule if the transmitter never reports completion.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `TIMEOUT_CYCLES`, default 1_200_000: maximum cycles spent in WAIT before abort. Covers one frame plus the transmitter's 20 ms post-frame delay at 50 MHz.
- `clk`, input, 1: the block's single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, NUM_REQ: request per requester; a level signal, held until `ack`.
- `req_data`, input, 8*NUM_REQ: byte of requester i at bits [8i+7:8i]; stable while `req[i]` is high.
- `ack`, output, NUM_REQ: one-cycle pulse to the requester whose byte completed.
- `tx_data`, output, 8: byte presented to the transmitter.
- `tx_send`, output, 1: one-cycle start pulse to the transmitter.
- `tx_finish`, input, 1: transmitter completion flag; a sticky level.
- `busy`, output, 1: high in every state except IDLE.
- `active_id`, output, $clog2(NUM_REQ): index of the requester being served.
- `timeout_err`, output, 1: one-cycle pulse when a transfer is aborted.

## Operation
- FSM states: IDLE, SEND, WAIT, DONE. All outputs are registered.
- **IDLE**
  - If any `req` bit is high, select the first set bit searching upward from `rr_ptr` with wrap-around.
  - In the same edge, latch that byte into `tx_data`, the index into `active_id`, and go to SEND.
  - If no `req` bit is high, stay in IDLE.
- **SEND**
  - `tx_send`=1 for exactly this cycle.
  - Clear the watchdog and go to WAIT.
- **WAIT**
  - The watchdog increments each cycle.
  - On a rising edge of `tx_finish` (`tx_finish & ~tx_finish_q`), go to DONE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with no edge, pulse `timeout_err`, advance `rr_ptr`, and go to IDLE without `ack`.
  - If the edge and the timeout occur in the same cycle, the edge wins: go to DONE with no `timeout_err`.
- **DONE**
  - `ack[active_id]`=1 for this cycle.
  - `rr_ptr` = `active_id`+1, wrapping NUM_REQ-1 to 0.
  - Go to IDLE.
- `tx_finish_q` is a 1-bit register that samples `tx_finish` every cycle. A `tx_finish` that is already high on entry to WAIT never completes a transfer; a fresh 0 to 1 edge is required.
- `tx_data` and `active_id` hold their values from SEND through the DONE cycle, and remain unchanged in IDLE until the next grant.
- If the served requester drops `req` mid-transfer, the transfer still completes and the `ack` is still issued.
- `req` bits of other requesters are ignored while `busy` is high.
- Watchdog width is $clog2(TIMEOUT_CYCLES). It saturates and never wraps.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `tx_finish_q` 0, watchdog 0.
  - Outputs `ack`, `tx_data`, `tx_send`, `busy`, `active_id`, `timeout_err` all 0.
- Reset mid-transfer:
  - Return to IDLE the next edge with no `ack` and no `timeout_err`.
  - An in-flight UART frame is not cancelled by this block.
- Latency:
  - `req` sampled at edge k gives `tx_send` high in cycle k+1 and `busy` high from k+1.
  - A `tx_finish` rising edge at edge m gives DONE in cycle m+1, with `ack` high in m+1.
  - The earliest next grant is sampled at edge m+2, so the next `tx_send` is in cycle m+3.
- Minimum spacing between consecutive `tx_send` pulses is 4 cycles, plus the transmitter time.
- Fairness: a requester holding `req` is served within NUM_REQ grants.

## Test plan
- **Single requester:** `req`=0001, `req_data[7:0]`=0xA5; drive `tx_finish` 0 to 1 at 20 cycles after `tx_send`.
  - `tx_send` pulses once with `tx_data`=0xA5 and `active_id`=0.
  - `ack`=0001 pulses one cycle after the edge.
  - `busy` returns to 0 after DONE.
- **Round-robin:** `req`=1111 held continuously, bytes 0x10/0x11/0x12/0x13, completion model returns an edge after each send.
  - Grants occur in order 0,1,2,3,0.
  - Exactly one `ack` bit is high per transfer.
- **Wrap-around:** after serving id 3, raise `req`=1001. The next grant is id 0; the one after it is id 3.
- **Stale finish:** hold `tx_finish`=1 through SEND and 50 WAIT cycles.
  - No `ack` occurs.
  - Drop `tx_finish` to 0, then raise it to 1: `ack` pulses.
- **Timeout:** TIMEOUT_CYCLES=16 and `tx_finish` stuck at 0.
  - `timeout_err` pulses exactly 16 cycles after entering WAIT, with no `ack`.
  - The next grant goes to the next requester.
  - With the edge coinciding with the last cycle, `ack` pulses instead of `timeout_err`.
- **Reset mid-WAIT:** assert `rst` for 1 cycle. All outputs read 0 on the next cycle, and a fresh `req` is granted starting from id 0.
